// File: rtl/ref_window_feeder.sv
// Reference window feeder: packs 8-pixel beats into a 15x15 window and streams its rows.
// Optional WIN_COUNT_EN adds a 16-bit count of fully drained windows (win_count).
module ref_window_feeder #(
  parameter int PIX_W         = 8,
  parameter int WIN_DIM       = 15,
  parameter int BEAT_PIX      = 8,
  parameter int BEATS_PER_ROW = 2
) (
  input  logic                               clk,
  input  logic                               reset_L,
  input  logic                               abort,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [BEAT_PIX*PIX_W-1:0]          in_data,
  output logic                               win_valid,
  output logic [WIN_DIM*WIN_DIM*PIX_W-1:0]   window,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [WIN_DIM*PIX_W-1:0]           out_row,
  output logic [3:0]                         out_row_idx
`ifdef WIN_COUNT_EN
  ,
  output logic [15:0]                        win_count
`endif
);

  localparam int ROW_W  = WIN_DIM * PIX_W;
  localparam int WIN_W  = WIN_DIM * ROW_W;
  localparam int BEAT_W = BEAT_PIX * PIX_W;
  localparam int TAIL_W = (WIN_DIM - BEAT_PIX) * PIX_W;
  localparam int NBEATS = WIN_DIM * BEATS_PER_ROW;

  localparam logic [4:0] LAST_BEAT = 5'(NBEATS - 1);
  localparam logic [3:0] LAST_ROW  = 4'(WIN_DIM - 1);

  localparam logic [0:0] S_LOAD   = 1'b0;
  localparam logic [0:0] S_STREAM = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [4:0]       beat_q, beat_d;
  logic [3:0]       row_q, row_d;
  logic [WIN_W-1:0] win_q;

  logic        in_fire;
  logic        out_fire;
  logic        last_row;
  logic [3:0]  wr_row;
  logic [10:0] wr_base;
  logic        unused_hi;

  assign in_ready    = (state_q == S_LOAD);
  assign out_valid   = (state_q == S_STREAM);
  assign win_valid   = out_valid;
  assign window      = win_q;
  assign out_row_idx = row_q;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign last_row = (row_q == LAST_ROW);

  // Beat pair 2r/2r+1 fills window row r; odd beats carry the 7-pixel tail.
  assign wr_row    = beat_q[4:1];
  assign wr_base   = 11'(wr_row) * 11'(ROW_W);
  assign unused_hi = ^in_data[BEAT_W-1:TAIL_W];

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    row_d   = row_q;
    if (abort) begin
      state_d = S_LOAD;
      beat_d  = '0;
      row_d   = '0;
    end else if (in_fire) begin
      if (beat_q == LAST_BEAT) begin
        state_d = S_STREAM;
        beat_d  = '0;
      end else begin
        beat_d = beat_q + 5'd1;
      end
    end else if (out_fire) begin
      if (last_row) begin
        state_d = S_LOAD;
        row_d   = '0;
      end else begin
        row_d = row_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= S_LOAD;
      beat_q  <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      row_q   <= row_d;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      win_q <= '0;
    end else if (in_fire && !abort) begin
      if (beat_q[0]) begin
        win_q[wr_base + 11'(BEAT_W) +: TAIL_W] <= in_data[TAIL_W-1:0];
      end else begin
        win_q[wr_base +: BEAT_W] <= in_data;
      end
    end
  end

  logic [ROW_W-1:0] rows [WIN_DIM];

  for (genvar r = 0; r < WIN_DIM; r++) begin : g_rows
    assign rows[r] = win_q[r*ROW_W +: ROW_W];
  end

  always_comb begin
    out_row = '0;
    if (row_q <= LAST_ROW) begin
      out_row = rows[row_q];
    end
  end

`ifdef WIN_COUNT_EN
  logic [15:0] win_count_q;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      win_count_q <= '0;
    end else if (out_fire && last_row && !abort) begin
      win_count_q <= win_count_q + 16'd1;
    end
  end

  assign win_count = win_count_q;
`endif

endmodule
